// File: rtl/id_ex_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage.
// Contents: default datapath widths, ALU opcode encodings carried to execute,
// and the hard-wired zero register address.
package id_ex_operand_stage_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int ALU_OP_WIDTH   = 5;

   localparam logic [REG_ADDR_WIDTH-1:0] REG_X0 = '0;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 5'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_LUI  = 5'd10;

endpackage

// File: rtl/id_ex_operand_stage_operand_bypass_mux.sv
// Combinational operand resolver for one source register.
// Ports:
//   rs_address        source register address
//   rf_data           register file read data for that address
//   mem_rd_*          MEM-stage destination, write enable and result
//   wb_rd_*           WB-stage destination, write enable and write data
//   operand           resolved value (MEM over WB over register file; x0 reads 0)
module operand_bypass_mux #(
   parameter int DATA_WIDTH     = id_ex_operand_stage_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = id_ex_operand_stage_pkg::REG_ADDR_WIDTH
) (
   input  logic [REG_ADDR_WIDTH-1:0] rs_address,
   input  logic [DATA_WIDTH-1:0]     rf_data,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd_address,
   input  logic                      mem_rd_write_en,
   input  logic [DATA_WIDTH-1:0]     mem_result,
   input  logic [REG_ADDR_WIDTH-1:0] wb_rd_address,
   input  logic                      wb_rd_write_en,
   input  logic [DATA_WIDTH-1:0]     wb_rd_data,
   output logic [DATA_WIDTH-1:0]     operand
);
   import id_ex_operand_stage_pkg::*;

   logic mem_hit;
   logic wb_hit;

   // A nonzero check on the producer side keeps a stray x0 write from
   // being forwarded; the final x0 override below covers the consumer side.
   assign mem_hit = mem_rd_write_en && (mem_rd_address == rs_address) && (mem_rd_address != REG_X0);
   assign wb_hit  = wb_rd_write_en  && (wb_rd_address  == rs_address) && (wb_rd_address  != REG_X0);

   always_comb begin
      operand = rf_data;
      if (rs_address == REG_X0) begin
         operand = '0;
      end else if (mem_hit) begin
         operand = mem_result;
      end else if (wb_hit) begin
         operand = wb_rd_data;
      end
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass and load-use detection.
// Ports:
//   CLK, RSTN                 clock, asynchronous active-low reset
//   ID_*                      decoded instruction from decode, ID_VALID/ID_READY handshake
//   RS1_DATA, RS2_DATA        register file read data
//   MEM_*, WB_*               bypass sources from the MEM and WB stages
//   FLUSH                     redirect: kill captured and held instruction
//   EX_READY, EX_VALID, EX_*  held instruction toward execute
//   LOAD_USE_STALL(_COUNT)    hazard indication and saturating stall counter
module id_ex_operand_stage #(
   parameter int DATA_WIDTH      = id_ex_operand_stage_pkg::DATA_WIDTH,
   parameter int REG_ADDR_WIDTH  = id_ex_operand_stage_pkg::REG_ADDR_WIDTH,
   parameter int ALU_OP_WIDTH    = id_ex_operand_stage_pkg::ALU_OP_WIDTH,
   parameter int STALL_CNT_WIDTH = 32
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       ID_VALID,
   output logic                       ID_READY,
   input  logic [DATA_WIDTH-1:0]      ID_PC,
   input  logic [REG_ADDR_WIDTH-1:0]  ID_RS1_ADDRESS,
   input  logic [REG_ADDR_WIDTH-1:0]  ID_RS2_ADDRESS,
   input  logic                       ID_USES_RS1,
   input  logic                       ID_USES_RS2,
   input  logic [REG_ADDR_WIDTH-1:0]  ID_RD_ADDRESS,
   input  logic                       ID_RD_WRITE_EN,
   input  logic                       ID_IS_LOAD,
   input  logic [DATA_WIDTH-1:0]      ID_IMM,
   input  logic [ALU_OP_WIDTH-1:0]    ID_ALU_OP,
   input  logic [DATA_WIDTH-1:0]      RS1_DATA,
   input  logic [DATA_WIDTH-1:0]      RS2_DATA,
   input  logic [REG_ADDR_WIDTH-1:0]  MEM_RD_ADDRESS,
   input  logic                       MEM_RD_WRITE_EN,
   input  logic [DATA_WIDTH-1:0]      MEM_RESULT,
   input  logic [REG_ADDR_WIDTH-1:0]  WB_RD_ADDRESS,
   input  logic                       WB_RD_WRITE_EN,
   input  logic [DATA_WIDTH-1:0]      WB_RD_DATA,
   input  logic                       FLUSH,
   input  logic                       EX_READY,
   output logic                       EX_VALID,
   output logic [DATA_WIDTH-1:0]      EX_PC,
   output logic [DATA_WIDTH-1:0]      EX_RS1_VALUE,
   output logic [DATA_WIDTH-1:0]      EX_RS2_VALUE,
   output logic [DATA_WIDTH-1:0]      EX_IMM,
   output logic [REG_ADDR_WIDTH-1:0]  EX_RD_ADDRESS,
   output logic                       EX_RD_WRITE_EN,
   output logic                       EX_IS_LOAD,
   output logic [ALU_OP_WIDTH-1:0]    EX_ALU_OP,
   output logic                       LOAD_USE_STALL,
   output logic [STALL_CNT_WIDTH-1:0] LOAD_USE_STALL_COUNT
);
   import id_ex_operand_stage_pkg::*;

   logic [DATA_WIDTH-1:0]      rs1_value_p0;
   logic [DATA_WIDTH-1:0]      rs2_value_p0;
   logic                       accept_p0;

   logic                       vld_p1;
   logic [DATA_WIDTH-1:0]      pc_p1;
   logic [DATA_WIDTH-1:0]      rs1_value_p1;
   logic [DATA_WIDTH-1:0]      rs2_value_p1;
   logic [DATA_WIDTH-1:0]      imm_p1;
   logic [REG_ADDR_WIDTH-1:0]  rd_address_p1;
   logic                       rd_write_en_p1;
   logic                       is_load_p1;
   logic [ALU_OP_WIDTH-1:0]    alu_op_p1;
   logic [STALL_CNT_WIDTH-1:0] stall_count;

   operand_bypass_mux #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_rs1_bypass (
      .rs_address      (ID_RS1_ADDRESS),
      .rf_data         (RS1_DATA),
      .mem_rd_address  (MEM_RD_ADDRESS),
      .mem_rd_write_en (MEM_RD_WRITE_EN),
      .mem_result      (MEM_RESULT),
      .wb_rd_address   (WB_RD_ADDRESS),
      .wb_rd_write_en  (WB_RD_WRITE_EN),
      .wb_rd_data      (WB_RD_DATA),
      .operand         (rs1_value_p0)
   );

   operand_bypass_mux #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_rs2_bypass (
      .rs_address      (ID_RS2_ADDRESS),
      .rf_data         (RS2_DATA),
      .mem_rd_address  (MEM_RD_ADDRESS),
      .mem_rd_write_en (MEM_RD_WRITE_EN),
      .mem_result      (MEM_RESULT),
      .wb_rd_address   (WB_RD_ADDRESS),
      .wb_rd_write_en  (WB_RD_WRITE_EN),
      .wb_rd_data      (WB_RD_DATA),
      .operand         (rs2_value_p0)
   );

   // A load held in EX has no data yet, so a dependent decode instruction
   // must wait one cycle until the load reaches MEM and can be bypassed.
   assign LOAD_USE_STALL = ID_VALID && vld_p1 && is_load_p1 && rd_write_en_p1
                           && (rd_address_p1 != REG_X0)
                           && ((ID_USES_RS1 && (ID_RS1_ADDRESS == rd_address_p1))
                            || (ID_USES_RS2 && (ID_RS2_ADDRESS == rd_address_p1)));

   // During a flush decode is told "ready" so it drains the wrong-path
   // instruction; the capture below is suppressed by FLUSH priority.
   assign ID_READY  = FLUSH || ((!vld_p1 || EX_READY) && !LOAD_USE_STALL);
   assign accept_p0 = ID_VALID && ID_READY;

   // ---- ID -> EX stage boundary ----
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         vld_p1         <= 1'b0;
         pc_p1          <= '0;
         rs1_value_p1   <= '0;
         rs2_value_p1   <= '0;
         imm_p1         <= '0;
         rd_address_p1  <= '0;
         rd_write_en_p1 <= 1'b0;
         is_load_p1     <= 1'b0;
         alu_op_p1      <= '0;
      end else if (FLUSH) begin
         vld_p1 <= 1'b0;
      end else if (accept_p0) begin
         vld_p1         <= 1'b1;
         pc_p1          <= ID_PC;
         rs1_value_p1   <= rs1_value_p0;
         rs2_value_p1   <= rs2_value_p0;
         imm_p1         <= ID_IMM;
         rd_address_p1  <= ID_RD_ADDRESS;
         rd_write_en_p1 <= ID_RD_WRITE_EN;
         is_load_p1     <= ID_IS_LOAD;
         alu_op_p1      <= ID_ALU_OP;
      end else if (EX_READY) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         stall_count <= '0;
      end else if (LOAD_USE_STALL && !FLUSH && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

   assign EX_VALID             = vld_p1;
   assign EX_PC                = pc_p1;
   assign EX_RS1_VALUE         = rs1_value_p1;
   assign EX_RS2_VALUE         = rs2_value_p1;
   assign EX_IMM               = imm_p1;
   assign EX_RD_ADDRESS        = rd_address_p1;
   assign EX_RD_WRITE_EN       = rd_write_en_p1;
   assign EX_IS_LOAD           = is_load_p1;
   assign EX_ALU_OP            = alu_op_p1;
   assign LOAD_USE_STALL_COUNT = stall_count;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed self-checking bench for id_ex_operand_stage.
module tb_id_ex_operand_stage;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int OW = 5;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          ID_VALID, ID_READY;
   logic [DW-1:0] ID_PC, ID_IMM, RS1_DATA, RS2_DATA, MEM_RESULT, WB_RD_DATA;
   logic [AW-1:0] ID_RS1_ADDRESS, ID_RS2_ADDRESS, ID_RD_ADDRESS, MEM_RD_ADDRESS, WB_RD_ADDRESS;
   logic          ID_USES_RS1, ID_USES_RS2, ID_RD_WRITE_EN, ID_IS_LOAD;
   logic [OW-1:0] ID_ALU_OP, EX_ALU_OP;
   logic          MEM_RD_WRITE_EN, WB_RD_WRITE_EN, FLUSH, EX_READY, EX_VALID;
   logic [DW-1:0] EX_PC, EX_RS1_VALUE, EX_RS2_VALUE, EX_IMM;
   logic [AW-1:0] EX_RD_ADDRESS;
   logic          EX_RD_WRITE_EN, EX_IS_LOAD, LOAD_USE_STALL;
   logic [CW-1:0] LOAD_USE_STALL_COUNT;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   id_ex_operand_stage #(
      .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .ALU_OP_WIDTH(OW), .STALL_CNT_WIDTH(CW)
   ) dut (
      .CLK(CLK), .RSTN(RSTN),
      .ID_VALID(ID_VALID), .ID_READY(ID_READY), .ID_PC(ID_PC),
      .ID_RS1_ADDRESS(ID_RS1_ADDRESS), .ID_RS2_ADDRESS(ID_RS2_ADDRESS),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
      .ID_RD_ADDRESS(ID_RD_ADDRESS), .ID_RD_WRITE_EN(ID_RD_WRITE_EN),
      .ID_IS_LOAD(ID_IS_LOAD), .ID_IMM(ID_IMM), .ID_ALU_OP(ID_ALU_OP),
      .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA),
      .MEM_RD_ADDRESS(MEM_RD_ADDRESS), .MEM_RD_WRITE_EN(MEM_RD_WRITE_EN), .MEM_RESULT(MEM_RESULT),
      .WB_RD_ADDRESS(WB_RD_ADDRESS), .WB_RD_WRITE_EN(WB_RD_WRITE_EN), .WB_RD_DATA(WB_RD_DATA),
      .FLUSH(FLUSH), .EX_READY(EX_READY), .EX_VALID(EX_VALID),
      .EX_PC(EX_PC), .EX_RS1_VALUE(EX_RS1_VALUE), .EX_RS2_VALUE(EX_RS2_VALUE), .EX_IMM(EX_IMM),
      .EX_RD_ADDRESS(EX_RD_ADDRESS), .EX_RD_WRITE_EN(EX_RD_WRITE_EN), .EX_IS_LOAD(EX_IS_LOAD),
      .EX_ALU_OP(EX_ALU_OP), .LOAD_USE_STALL(LOAD_USE_STALL),
      .LOAD_USE_STALL_COUNT(LOAD_USE_STALL_COUNT)
   );

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
         $error("%s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are checked 1ns after the edge.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic present(input logic [DW-1:0] pc, input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2, input logic [AW-1:0] rd,
                          input logic ld);
      ID_VALID       = 1'b1;
      ID_PC          = pc;
      ID_RS1_ADDRESS = rs1;
      ID_USES_RS1    = u1;
      ID_RS2_ADDRESS = rs2;
      ID_USES_RS2    = u2;
      ID_RD_ADDRESS  = rd;
      ID_RD_WRITE_EN = 1'b1;
      ID_IS_LOAD     = ld;
   endtask

   initial begin
      RSTN = 1'b0; ID_VALID = 1'b0; ID_PC = '0; ID_IMM = '0; ID_ALU_OP = '0;
      ID_RS1_ADDRESS = '0; ID_RS2_ADDRESS = '0; ID_USES_RS1 = 1'b0; ID_USES_RS2 = 1'b0;
      ID_RD_ADDRESS = '0; ID_RD_WRITE_EN = 1'b0; ID_IS_LOAD = 1'b0;
      RS1_DATA = '0; RS2_DATA = '0;
      MEM_RD_ADDRESS = '0; MEM_RD_WRITE_EN = 1'b0; MEM_RESULT = '0;
      WB_RD_ADDRESS = '0; WB_RD_WRITE_EN = 1'b0; WB_RD_DATA = '0;
      FLUSH = 1'b0; EX_READY = 1'b1;

      step(); step();
      chk("reset_ex_valid", {31'b0, EX_VALID}, 32'd0);
      chk("reset_ex_pc", EX_PC, 32'd0);
      chk("reset_count", {28'b0, LOAD_USE_STALL_COUNT}, 32'd0);
      RSTN = 1'b1;
      step();

      // Bypass priority on rs1 = x5; rs2 = x6 comes from the register file.
      present(32'h100, 5'd5, 1'b1, 5'd6, 1'b1, 5'd3, 1'b0);
      ID_IMM = 32'h4; ID_ALU_OP = 5'd1;
      RS1_DATA = 32'h11; RS2_DATA = 32'h66;
      WB_RD_ADDRESS = 5'd5;  WB_RD_WRITE_EN = 1'b1;  WB_RD_DATA = 32'h22;
      MEM_RD_ADDRESS = 5'd5; MEM_RD_WRITE_EN = 1'b1; MEM_RESULT = 32'h33;
      #1;
      chk("idle_id_ready", {31'b0, ID_READY}, 32'd1);
      step();
      chk("cap_ex_valid", {31'b0, EX_VALID}, 32'd1);
      chk("byp_mem", EX_RS1_VALUE, 32'h33);
      chk("rs2_regfile", EX_RS2_VALUE, 32'h66);
      chk("cap_pc", EX_PC, 32'h100);
      chk("cap_imm", EX_IMM, 32'h4);
      MEM_RD_WRITE_EN = 1'b0; ID_PC = 32'h104;
      step();
      chk("byp_wb", EX_RS1_VALUE, 32'h22);
      WB_RD_WRITE_EN = 1'b0; ID_PC = 32'h108;
      step();
      chk("byp_rf", EX_RS1_VALUE, 32'h11);
      ID_RS1_ADDRESS = 5'd0; ID_PC = 32'h10c;
      MEM_RD_ADDRESS = 5'd0; MEM_RD_WRITE_EN = 1'b1;
      WB_RD_ADDRESS = 5'd0;  WB_RD_WRITE_EN = 1'b1;
      step();
      chk("byp_x0", EX_RS1_VALUE, 32'h0);
      MEM_RD_WRITE_EN = 1'b0; WB_RD_WRITE_EN = 1'b0;

      // Load-use: load x7 in EX, dependent add in ID.
      present(32'h200, 5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1);
      step();
      present(32'h204, 5'd7, 1'b1, 5'd2, 1'b0, 5'd8, 1'b0);
      RS1_DATA = 32'h1111;
      #1;
      chk("lu_stall", {31'b0, LOAD_USE_STALL}, 32'd1);
      chk("lu_id_ready", {31'b0, ID_READY}, 32'd0);
      step();
      chk("lu_bubble", {31'b0, EX_VALID}, 32'd0);
      chk("lu_count1", {28'b0, LOAD_USE_STALL_COUNT}, 32'd1);
      MEM_RD_ADDRESS = 5'd7; MEM_RD_WRITE_EN = 1'b1; MEM_RESULT = 32'hDEAD;
      #1;
      chk("lu_released", {31'b0, ID_READY}, 32'd1);
      step();
      chk("lu_cap_valid", {31'b0, EX_VALID}, 32'd1);
      chk("lu_cap_pc", EX_PC, 32'h204);
      chk("lu_byp_dead", EX_RS1_VALUE, 32'hDEAD);
      MEM_RD_WRITE_EN = 1'b0;

      // No false stall when x7 appears only on an unused rs2.
      present(32'h300, 5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1);
      step();
      present(32'h304, 5'd2, 1'b1, 5'd7, 1'b0, 5'd9, 1'b0);
      #1;
      chk("nfs_stall", {31'b0, LOAD_USE_STALL}, 32'd0);
      chk("nfs_id_ready", {31'b0, ID_READY}, 32'd1);
      step();
      chk("nfs_cap_pc", EX_PC, 32'h304);

      // Backpressure for three cycles, then release.
      EX_READY = 1'b0;
      present(32'h400, 5'd2, 1'b1, 5'd3, 1'b0, 5'd10, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_id_ready", {31'b0, ID_READY}, 32'd0);
         step();
         chk("bp_pc_hold", EX_PC, 32'h304);
         chk("bp_valid_hold", {31'b0, EX_VALID}, 32'd1);
      end
      EX_READY = 1'b1;
      #1;
      chk("bp_release_ready", {31'b0, ID_READY}, 32'd1);
      step();
      chk("bp_release_pc", EX_PC, 32'h400);

      // Flush beats capture and hold; payload stays put.
      EX_READY = 1'b0;
      present(32'h500, 5'd2, 1'b1, 5'd3, 1'b0, 5'd11, 1'b0);
      FLUSH = 1'b1;
      #1;
      chk("fl_id_ready", {31'b0, ID_READY}, 32'd1);
      step();
      chk("fl_valid", {31'b0, EX_VALID}, 32'd0);
      chk("fl_pc_kept", EX_PC, 32'h400);
      FLUSH = 1'b0;

      // A stall cycle coinciding with flush is not counted.
      present(32'h600, 5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1);
      step();
      present(32'h604, 5'd7, 1'b1, 5'd2, 1'b0, 5'd8, 1'b0);
      FLUSH = 1'b1;
      #1;
      chk("flst_stall", {31'b0, LOAD_USE_STALL}, 32'd1);
      step();
      chk("flst_count", {28'b0, LOAD_USE_STALL_COUNT}, 32'd1);
      FLUSH = 1'b0;

      // Saturation: hold a stall with EX_READY low well past 15 cycles.
      present(32'h700, 5'd1, 1'b1, 5'd2, 1'b0, 5'd7, 1'b1);
      step();
      present(32'h704, 5'd7, 1'b1, 5'd2, 1'b0, 5'd8, 1'b0);
      for (int i = 0; i < 13; i++) step();
      chk("sat_count14", {28'b0, LOAD_USE_STALL_COUNT}, 32'd14);
      for (int i = 0; i < 7; i++) step();
      chk("sat_count15", {28'b0, LOAD_USE_STALL_COUNT}, 32'd15);
      chk("sat_pc_hold", EX_PC, 32'h700);

      // Asynchronous reset while holding PC 0x40.
      EX_READY = 1'b1;
      present(32'h40, 5'd1, 1'b1, 5'd2, 1'b0, 5'd4, 1'b0);
      ID_IMM = 32'h55; ID_ALU_OP = 5'd3; RS1_DATA = 32'h77;
      step();
      chk("pre_rst_pc", EX_PC, 32'h40);
      ID_VALID = 1'b0; EX_READY = 1'b0;
      #3;
      RSTN = 1'b0;
      #1;
      chk("arst_valid", {31'b0, EX_VALID}, 32'd0);
      chk("arst_pc", EX_PC, 32'h0);
      chk("arst_rs1", EX_RS1_VALUE, 32'h0);
      chk("arst_imm", EX_IMM, 32'h0);
      chk("arst_alu_op", {27'b0, EX_ALU_OP}, 32'h0);
      chk("arst_rd", {27'b0, EX_RD_ADDRESS}, 32'h0);
      chk("arst_we", {31'b0, EX_RD_WRITE_EN}, 32'h0);
      chk("arst_count", {28'b0, LOAD_USE_STALL_COUNT}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
